// File: rtl/addr_unmap.sv
// Reverse-mapping table for the two-coefficient address hash: remembers the last
// address written into each bucket and decodes a bucket index back to that address.
module addr_unmap #(
    parameter int          ADDR_WIDTH = 64,
    parameter int          IDX_W      = 4,
    parameter logic [31:0] DEF_A      = 32'h0000_0001,
    parameter logic [31:0] DEF_B      = 32'h0000_0001
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  coe_valid,
    input  logic [31:0]           coe_a_in,
    input  logic [31:0]           coe_b_in,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    input  logic [ADDR_WIDTH-1:0] ins_addr,
    output logic                  ins_done,
    output logic [IDX_W-1:0]      ins_idx,
    output logic                  ins_collide,
    input  logic                  lk_valid,
    output logic                  lk_ready,
    input  logic [IDX_W-1:0]      lk_idx,
    output logic                  rsp_valid,
    output logic                  rsp_hit,
    output logic [ADDR_WIDTH-1:0] rsp_addr,
    output logic                  flushing
);

    localparam int DEPTH = 2 ** IDX_W;

    typedef enum logic {
        FLUSH,
        RUN
    } state_t;

    state_t                 state;
    logic [IDX_W-1:0]       cnt;
    logic [31:0]            coe_a;
    logic [31:0]            coe_b;

    logic                   s1_valid;
    logic [31:0]            s1_pa;
    logic [31:0]            s1_pb;
    logic [ADDR_WIDTH-1:0]  s1_addr;

    logic                   s2_valid;
    logic [IDX_W-1:0]       s2_idx;
    logic [ADDR_WIDTH-1:0]  s2_addr;

    logic [ADDR_WIDTH-1:0]  tbl_addr [DEPTH];
    logic [DEPTH-1:0]       tbl_valid;

    logic                   ins_acc;
    logic                   lk_acc;
    logic [31:0]            hash_sum;
    logic                   s2_collide;

    // Coefficient loads win over requests in the same cycle.
    assign ins_acc    = ins_valid && ins_ready && !coe_valid;
    assign lk_acc     = lk_valid && lk_ready && !coe_valid;
    assign hash_sum   = s1_pa + s1_pb;

    // The table is a flop array, so the write of the preceding insert is
    // already visible here; no separate bypass path is needed.
    assign s2_collide = tbl_valid[s2_idx] && (tbl_addr[s2_idx] != s2_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FLUSH;
            cnt         <= '0;
            coe_a       <= DEF_A;
            coe_b       <= DEF_B;
            ins_ready   <= 1'b0;
            lk_ready    <= 1'b0;
            flushing    <= 1'b1;
            s1_valid    <= 1'b0;
            s2_valid    <= 1'b0;
            ins_done    <= 1'b0;
            ins_idx     <= '0;
            ins_collide <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_hit     <= 1'b0;
            rsp_addr    <= '0;
        end else begin
            ins_done  <= 1'b0;
            rsp_valid <= 1'b0;

            s1_valid  <= ins_acc;
            s1_pa     <= coe_a * ins_addr[ADDR_WIDTH-1:32];
            s1_pb     <= coe_b * ins_addr[31:0];
            s1_addr   <= ins_addr;

            s2_valid  <= s1_valid;
            s2_idx    <= hash_sum[31 -: IDX_W];
            s2_addr   <= s1_addr;

            // Read-before-write: a lookup sees the table as it was before this edge.
            if (lk_acc) begin
                rsp_valid <= 1'b1;
                rsp_hit   <= tbl_valid[lk_idx];
                rsp_addr  <= tbl_valid[lk_idx] ? tbl_addr[lk_idx] : '0;
            end

            if (s2_valid && !coe_valid) begin
                tbl_addr[s2_idx]  <= s2_addr;
                tbl_valid[s2_idx] <= 1'b1;
                ins_done          <= 1'b1;
                ins_idx           <= s2_idx;
                ins_collide       <= s2_collide;
            end

            if (coe_valid) begin
                coe_a     <= coe_a_in;
                coe_b     <= coe_b_in;
                state     <= FLUSH;
                cnt       <= '0;
                ins_ready <= 1'b0;
                lk_ready  <= 1'b0;
                flushing  <= 1'b1;
                s1_valid  <= 1'b0;
                s2_valid  <= 1'b0;
            end else begin
                case (state)
                    FLUSH: begin
                        tbl_valid[cnt] <= 1'b0;
                        cnt            <= cnt + 1'b1;
                        if (&cnt) begin
                            state     <= RUN;
                            ins_ready <= 1'b1;
                            lk_ready  <= 1'b1;
                            flushing  <= 1'b0;
                        end
                    end
                    RUN: begin
                        ins_ready <= 1'b1;
                        lk_ready  <= 1'b1;
                        flushing  <= 1'b0;
                    end
                    default: state <= FLUSH;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_addr_unmap.sv
// Randomized scoreboard bench for addr_unmap against a cycle-level behavioural
// model of the bucket table, flush timing and insert latency.
module tb_addr_unmap;

    logic        clk = 1'b0;
    logic        rst;
    logic        coe_valid;
    logic [31:0] coe_a_in;
    logic [31:0] coe_b_in;
    logic        ins_valid;
    logic        ins_ready;
    logic [63:0] ins_addr;
    logic        ins_done;
    logic [3:0]  ins_idx;
    logic        ins_collide;
    logic        lk_valid;
    logic        lk_ready;
    logic [3:0]  lk_idx;
    logic        rsp_valid;
    logic        rsp_hit;
    logic [63:0] rsp_addr;
    logic        flushing;

    always #5 clk = ~clk;

    addr_unmap #(
        .ADDR_WIDTH(64),
        .IDX_W     (4),
        .DEF_A     (32'h0000_0001),
        .DEF_B     (32'h0000_0001)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .coe_valid  (coe_valid),
        .coe_a_in   (coe_a_in),
        .coe_b_in   (coe_b_in),
        .ins_valid  (ins_valid),
        .ins_ready  (ins_ready),
        .ins_addr   (ins_addr),
        .ins_done   (ins_done),
        .ins_idx    (ins_idx),
        .ins_collide(ins_collide),
        .lk_valid   (lk_valid),
        .lk_ready   (lk_ready),
        .lk_idx     (lk_idx),
        .rsp_valid  (rsp_valid),
        .rsp_hit    (rsp_hit),
        .rsp_addr   (rsp_addr),
        .flushing   (flushing)
    );

    typedef struct {
        int unsigned cyc;
        logic [63:0] addr;
        logic [3:0]  idx;
    } pend_t;

    typedef struct {
        int unsigned cyc;
        logic [3:0]  idx;
        logic        col;
    } exp_ins_t;

    typedef struct {
        int unsigned cyc;
        logic        hit;
        logic [63:0] addr;
    } exp_rsp_t;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc    = 0;

    pend_t    pend[$];
    exp_ins_t eq_ins[$];
    exp_rsp_t eq_rsp[$];

    bit          mv [16];
    logic [63:0] ma [16];
    logic [31:0] m_a;
    logic [31:0] m_b;
    int unsigned flush_left = 0;
    bit          known = 0;

    logic [63:0] pool [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Bucket = top four bits of (a*upper + b*lower) mod 2^32.
    function automatic logic [3:0] model_idx(input logic [63:0] addr);
        longint unsigned up, lo, s;
        up = longint'(addr[63:32]);
        lo = longint'(addr[31:0]);
        s  = (longint'(m_a) * up + longint'(m_b) * lo) % 64'h1_0000_0000;
        return 4'(s / 64'h1000_0000);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) mv[i] = 1'b0;
        pend.delete();
    endtask

    task automatic begin_cycle();
        pend_t p;
        while (pend.size() > 0 && pend[0].cyc <= cyc) begin
            p = pend.pop_front();
            eq_ins.push_back('{cyc: p.cyc, idx: p.idx, col: (mv[p.idx] && ma[p.idx] != p.addr)});
            mv[p.idx] = 1'b1;
            ma[p.idx] = p.addr;
        end
        if (known) begin
            check("ins_ready", ins_ready, (flush_left == 0));
            check("lk_ready", lk_ready, (flush_left == 0));
            check("flushing", flushing, (flush_left != 0));
        end
    endtask

    task automatic step(input bit ins, input logic [63:0] ia, input bit lk, input logic [3:0] li,
                        input bit coe, input logic [31:0] ca, input logic [31:0] cb, input bit r);
        bit rdy;
        rdy       = known && (flush_left == 0);
        rst       = r;
        coe_valid = coe;
        coe_a_in  = ca;
        coe_b_in  = cb;
        ins_valid = ins;
        ins_addr  = ia;
        lk_valid  = lk;
        lk_idx    = li;
        if (!r && !coe && rdy) begin
            if (lk) eq_rsp.push_back('{cyc: cyc + 1, hit: mv[li], addr: (mv[li] ? ma[li] : 64'h0)});
            if (ins) pend.push_back('{cyc: cyc + 3, addr: ia, idx: model_idx(ia)});
        end
        if (r) begin
            m_a = 32'h1;
            m_b = 32'h1;
            model_clear();
            flush_left = 16;
            known = 1'b1;
        end else if (coe) begin
            m_a = ca;
            m_b = cb;
            model_clear();
            flush_left = 16;
        end else if (flush_left > 0) begin
            flush_left--;
        end
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b0; coe_valid = 1'b0; ins_valid = 1'b0; lk_valid = 1'b0;
        begin_cycle();
        if (r) begin
            check("rst_ins_done", ins_done, 0);
            check("rst_ins_idx", ins_idx, 0);
            check("rst_ins_collide", ins_collide, 0);
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_rsp_hit", rsp_hit, 0);
            check("rst_rsp_addr", rsp_addr, 0);
        end
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(0, 64'h0, 0, 4'h0, 0, 32'h0, 32'h0, 0);
    endtask

    task automatic insert(input logic [63:0] a);
        step(1, a, 0, 4'h0, 0, 32'h0, 32'h0, 0);
    endtask

    task automatic lookup(input logic [3:0] i);
        step(0, 64'h0, 1, i, 0, 32'h0, 32'h0, 0);
    endtask

    task automatic measure_flush(input string name);
        int unsigned n;
        n = 0;
        while (flushing === 1'b1 && n < 100) begin
            n++;
            idle(1);
        end
        check(name, n, 16);
    endtask

    // Monitor: compares every DUT response pulse against the expected queues.
    always @(negedge clk) begin
        exp_ins_t ei;
        exp_rsp_t er;
        while (eq_ins.size() > 0 && eq_ins[0].cyc < cyc) begin
            ei = eq_ins.pop_front();
            check("ins_done_missing", 0, 1);
        end
        while (eq_rsp.size() > 0 && eq_rsp[0].cyc < cyc) begin
            er = eq_rsp.pop_front();
            check("rsp_valid_missing", 0, 1);
        end
        if (ins_done === 1'b1) begin
            if (eq_ins.size() > 0 && eq_ins[0].cyc == cyc) begin
                ei = eq_ins.pop_front();
                check("ins_idx", ins_idx, ei.idx);
                check("ins_collide", ins_collide, ei.col);
            end else begin
                check("ins_done_unexpected", 1, 0);
            end
        end
        if (rsp_valid === 1'b1) begin
            if (eq_rsp.size() > 0 && eq_rsp[0].cyc == cyc) begin
                er = eq_rsp.pop_front();
                check("rsp_hit", rsp_hit, er.hit);
                check("rsp_addr", rsp_addr, er.addr);
            end else begin
                check("rsp_valid_unexpected", 1, 0);
            end
        end
    end

    localparam logic [63:0] A_ADDR = 64'haaaaaaaa_bbbbbbbb;
    localparam logic [63:0] B_ADDR = 64'h00000000_66666665;

    initial begin
        rst = 1'b1; coe_valid = 1'b0; coe_a_in = '0; coe_b_in = '0;
        ins_valid = 1'b0; ins_addr = '0; lk_valid = 1'b0; lk_idx = '0;
        m_a = 32'h1; m_b = 32'h1;
        for (int i = 0; i < 8; i++) pool[i] = {$urandom(), $urandom()};
        @(posedge clk);
        #1;
        cyc++;

        step(0, 64'h0, 0, 4'h0, 0, 32'h0, 32'h0, 1);
        measure_flush("flush_len_reset");
        for (int i = 0; i < 16; i++) lookup(4'(i));

        insert(A_ADDR);
        idle(2);
        check("plan_done_a", ins_done, 1);
        check("plan_idx_a", ins_idx, 6);
        check("plan_col_a", ins_collide, 0);
        lookup(4'd6);
        insert(B_ADDR);
        idle(2);
        check("plan_col_b", ins_collide, 1);
        lookup(4'd6);

        insert(A_ADDR);
        insert(B_ADDR);
        insert(B_ADDR);
        insert(B_ADDR);
        idle(4);

        insert(A_ADDR);
        insert(B_ADDR);
        step(0, 64'h0, 0, 4'h0, 1, 32'h2, 32'h0, 0);
        measure_flush("flush_len_coe");
        insert(64'h00000001_00000000);
        idle(2);
        check("plan_idx_zero", ins_idx, 0);
        for (int i = 0; i < 16; i++) lookup(4'(i));

        step(0, 64'h0, 0, 4'h0, 1, 32'h1, 32'h1, 0);
        measure_flush("flush_len_coe2");
        insert(A_ADDR);
        idle(3);
        insert(B_ADDR);
        idle(1);
        lookup(4'd6);
        lookup(4'd6);
        idle(2);

        step(0, 64'h0, 0, 4'h0, 1, 32'h3, 32'h5, 0);
        idle(5);
        step(0, 64'h0, 0, 4'h0, 0, 32'h0, 32'h0, 1);
        measure_flush("flush_len_midrst");

        for (int n = 0; n < 1500; n++) begin
            bit          r, c;
            logic [63:0] a;
            r = ($urandom_range(0, 599) == 0);
            c = ($urandom_range(0, 199) == 0);
            a = ($urandom_range(0, 3) == 0) ? {$urandom(), $urandom()} : pool[$urandom_range(0, 7)];
            step($urandom_range(0, 1) == 1, a, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
                 c, ($urandom_range(0, 1) == 1) ? $urandom() : 32'h1, $urandom(), r);
        end

        idle(8);
        check("ins_queue_drained", eq_ins.size() + pend.size(), 0);
        check("rsp_queue_drained", eq_rsp.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/addr_unmap.md
Name: addr_unmap

Overview:
- Reverse-mapping table for the address hash: records which 64-bit address was last mapped into each hash bucket, so a bucket index can be decoded back to its full address.
- Computes the same two-coefficient hash internally, writes the address at the hashed index, and answers index lookups.
- Loading new coefficients invalidates the whole table through a sequential flush.

Parameters:
- ADDR_WIDTH, 64, address width; fixed split into upper [63:32] and lower [31:0].
- IDX_W, 4, bucket index width; DEPTH = 2**IDX_W entries.
- DEF_A, 32'h0000_0001, coe_a value after reset.
- DEF_B, 32'h0000_0001, coe_b value after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- coe_valid  in  1  load new coefficients this cycle.
- coe_a_in  in  32  new coe_a.
- coe_b_in  in  32  new coe_b.
- ins_valid  in  1  insert request.
- ins_ready  out  1  insert accepted when ins_valid && ins_ready.
- ins_addr  in  ADDR_WIDTH  address to map.
- ins_done  out  1  one-cycle pulse; insert completed.
- ins_idx  out  IDX_W  bucket written.
- ins_collide  out  1  bucket held a valid, different address (overwritten).
- lk_valid  in  1  lookup request.
- lk_ready  out  1  lookup accepted when lk_valid && lk_ready.
- lk_idx  in  IDX_W  bucket to decode.
- rsp_valid  out  1  one-cycle lookup response pulse.
- rsp_hit  out  1  bucket valid.
- rsp_addr  out  ADDR_WIDTH  stored address; 0 when miss.
- flushing  out  1  high while in FLUSH.

Behaviour:
- Hash: sum = (coe_a*upper + coe_b*lower) mod 2^32, computed from the 32x32 products truncated to 32 bits. idx = sum[31:32-IDX_W].
- States: FLUSH, RUN.
- Reset:
  - coe_a=DEF_A, coe_b=DEF_B; state=FLUSH; flush counter=0.
  - All outputs 0, except flushing=1.
  - Pipeline valid bits cleared.
- FLUSH:
  - Clears valid[cnt] each cycle; cnt increments.
  - Moves to RUN after clearing entry DEPTH-1, so it takes exactly DEPTH cycles.
  - ins_ready=lk_ready=0 and flushing=1 throughout.
- RUN: ins_ready=lk_ready=1 and flushing=0.
- coe_valid (any state):
  - Latches coe_a_in/coe_b_in, enters FLUSH with cnt=0, which restarts any flush in progress.
  - Squashes in-flight inserts: no ins_done for them.
  - A response for a lookup already accepted still issues.
  - coe_valid has priority over ins_valid/lk_valid in the same cycle; neither is accepted.
- Insert pipeline:
  - Cycle T accept.
  - Stage 1 registers the products.
  - Stage 2 registers idx and the address.
  - At edge T+3, writes the table entry, sets valid, and pulses ins_done with ins_idx/ins_collide, so ins_done is visible in cycle T+3.
  - Fully pipelined at one insert per cycle.
  - ins_collide = valid[idx] && stored != addr, evaluated against the table contents including a write in the same cycle from the preceding insert (forwarded).
- Lookup: accept in cycle T; rsp_* is valid in cycle T+1.
- Table ordering: a lookup and a write to the same index in the same cycle returns the pre-write contents.
- Outputs ins_idx/ins_collide/rsp_hit/rsp_addr hold their last value when not pulsed.
- rst mid-operation: everything returns to reset state; the table is invalidated by the FLUSH that follows reset.
- Simultaneous insert and lookup in RUN: both accepted.

Test Plan:
- Reset then idle → flushing=1 for exactly 16 cycles (IDX_W=4), then ins_ready=lk_ready=1; a lookup of idx 0..15 gives rsp_hit=0, rsp_addr=0.
- Default coefficients, insert 64'haaaaaaaa_bbbbbbbb → ins_done 3 cycles after acceptance, ins_idx=6, ins_collide=0; lookup idx 6 → rsp_hit=1, rsp_addr=64'haaaaaaaa_bbbbbbbb.
- Then insert 64'h00000000_66666665 → ins_idx=6, ins_collide=1; lookup idx 6 → rsp_addr=64'h00000000_66666665.
- Back-to-back inserts aaaaaaaa_bbbbbbbb then 00000000_66666665 → second ins_collide=1 via forwarding; same address inserted twice → ins_collide=0.
- coe_valid with a=2, b=0 while two inserts are in flight → no ins_done for them; 16 flush cycles; then insert 64'h00000001_00000000 → idx=0 (sum=2), and all prior entries miss.
- Lookup of idx 6 in the same cycle its write completes → old contents returned; a lookup the next cycle returns the new address; rst asserted mid-flush → flush restarts from cnt=0.
